// File: rtl/div_arbiter.sv
// Two-requester round-robin front end for a shared signed divider.
// Zero divisors are answered locally without starting the divider.
module div_arbiter #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] a1,
    input  logic [M-1:0] b0,
    input  logic [M-1:0] b1,
    output logic         done0,
    output logic         done1,
    output logic [N-1:0] q_out,
    output logic [M-1:0] r_out,
    output logic         dz,
    output logic         busy,
    output logic         div_start,
    output logic [N-1:0] div_word1,
    output logic [M-1:0] div_word2,
    input  logic [N-1:0] div_quotient,
    input  logic [M-1:0] div_remainder,
    input  logic         div_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           owner_q, owner_d;
    logic           prio_q, prio_d;
    logic           seen_low_q, seen_low_d;
    logic [N-1:0]   word1_q, word1_d;
    logic [M-1:0]   word2_q, word2_d;
    logic [N-1:0]   quot_q, quot_d;
    logic [M-1:0]   rem_q, rem_d;
    logic           dz_q, dz_d;

    logic           grantSel;
    logic [N-1:0]   selA;
    logic [M-1:0]   selB;

    // prio_q names the requester that wins a tie: the one not served last
    assign grantSel = (req0 && req1) ? prio_q : req1;
    assign selA     = grantSel ? a1 : a0;
    assign selB     = grantSel ? b1 : b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            prio_q     <= 1'b0;
            seen_low_q <= 1'b0;
            word1_q    <= '0;
            word2_q    <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            dz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            prio_q     <= prio_d;
            seen_low_q <= seen_low_d;
            word1_q    <= word1_d;
            word2_q    <= word2_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dz_q       <= dz_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        prio_d     = prio_q;
        seen_low_d = seen_low_q;
        word1_d    = word1_q;
        word2_d    = word2_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dz_d       = dz_q;
        div_start  = 1'b0;
        done0      = 1'b0;
        done1      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d    = grantSel;
                    prio_d     = ~grantSel;
                    word1_d    = selA;
                    word2_d    = selB;
                    seen_low_d = 1'b0;
                    if (selB == '0) begin
                        quot_d  = '1;
                        rem_d   = selA[M-1:0];
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = START;
                    end
                end
            end
            START: begin
                div_start = 1'b1;
                state_d   = BUSY;
            end
            BUSY: begin
                // a ready left high from an earlier operation must be seen to drop first
                if (!div_ready) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    quot_d  = div_quotient;
                    rem_d   = div_remainder;
                    dz_d    = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                done0   = ~owner_q;
                done1   = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign div_word1 = word1_q;
    assign div_word2 = word2_q;
    assign q_out     = quot_q;
    assign r_out     = rem_q;
    assign dz        = dz_q;

endmodule
